bcd_to_freq: RTL and testbench



---
 rtl/dds_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bcd_to_freq.sv | 113 +++++++++++
 tb/tb_bcd_to_freq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Constants and types shared by the DDS frequency path (BCD entry, display, core).
package dds_pkg;

  localparam int DDS_FREQ_W = 18;
  localparam int DDS_DIGITS = 8;
  localparam int BCD_DIG_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Bits needed to hold any value of `digits` decimal digits: ceil(log2(10^digits)).
  function automatic int calc_bin_w(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a digit that reached >=8 after the shift is pulled back by 3.
module bcd_digit_adj
  import dds_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] d,
  output logic [BCD_DIG_W-1:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd_to_freq.sv
// Iterative BCD-to-binary frequency converter, one bit per clock, valid/ready on both sides.
// Optional build macro BCD_FREQ_CLAMP_EN: saturate f to all-ones on overflow instead of truncating.
module bcd_to_freq
  import dds_pkg::*;
#(
  parameter int DIGITS = DDS_DIGITS,
  parameter int FREQ_W = DDS_FREQ_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_DIG_W*DIGITS-1:0] bcd_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [FREQ_W-1:0]           f,
  output logic                        ovf,
  output logic                        err,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int BIN_W = calc_bin_w(DIGITS);
  localparam int BCD_W = BCD_DIG_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t       state, state_nxt;
  logic [SR_W-1:0]   sr, sr_sh, sr_adj;
  logic [CNT_W-1:0]  cnt;
  logic              err_lat;
  logic [DIGITS-1:0] dig_bad;
  logic              load, last;
  logic [BIN_W-1:0]  bin_fin;
  logic [FREQ_W-1:0] f_nxt;
  logic              ovf_nxt;

  assign sr_sh = sr >> 1;

  // Binary part passes straight through; each BCD digit is corrected independently.
  assign sr_adj[BIN_W-1:0] = sr_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .d (sr_sh[BIN_W + g*BCD_DIG_W +: BCD_DIG_W]),
      .q (sr_adj[BIN_W + g*BCD_DIG_W +: BCD_DIG_W])
    );
    assign dig_bad[g] = bcd_in[g*BCD_DIG_W +: BCD_DIG_W] > 4'd9;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (cnt == CNT_W'(1)) begin
        last      = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result is taken from the register value produced by the final shift.
  assign bin_fin = sr_adj[BIN_W-1:0];

  always_comb begin
    ovf_nxt = |bin_fin[BIN_W-1:FREQ_W];
    f_nxt   = bin_fin[FREQ_W-1:0];
`ifdef BCD_FREQ_CLAMP_EN
    if (ovf_nxt) f_nxt = '1;
`endif
    if (err_lat) begin
      f_nxt   = '0;
      ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      err_lat <= 1'b0;
      f       <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else if (load) begin
      sr      <= {bcd_in, {BIN_W{1'b0}}};
      cnt     <= CNT_W'(BIN_W);
      err_lat <= |dig_bad;
    end else if (state == SHIFT) begin
      sr  <= sr_adj;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        f   <= f_nxt;
        ovf <= ovf_nxt;
        err <= err_lat;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_freq.sv
// Directed bench for bcd_to_freq: latency, conversion values, overflow/error, back-pressure, reset abort.
module tb_bcd_to_freq;

  localparam int FREQ_W = 18;
  localparam int LAT    = 27;  // edges after the handshake edge until out_valid is seen (cycle N+28)

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       bcd_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FREQ_W-1:0] f;
  logic              ovf;
  logic              err;
  logic              out_valid;
  logic              out_ready = 1'b1;

  int vecs = 0;
  int miss = 0;

  bcd_to_freq dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f         (f),
    .ovf       (ovf),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    bcd_in   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bcd_in   = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin tick(); lat++; end
  endtask

  task automatic conv(input string tag, input logic [31:0] b,
                      input logic [17:0] ef, input logic eovf, input logic eerr);
    int lat;
    start(b);
    wait_out(lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_f"}, {14'd0, f}, {14'd0, ef});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
    tick();
    chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [17:0] f_hold;
    int lat;

    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_f", {14'd0, f}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();

    conv("c12345", 32'h00012345, 18'h03039, 1'b0, 1'b0);
    conv("c262143", 32'h00262143, 18'h3FFFF, 1'b0, 1'b0);
`ifdef BCD_FREQ_CLAMP_EN
    conv("c262144", 32'h00262144, 18'h3FFFF, 1'b1, 1'b0);
    conv("c9s", 32'h99999999, 18'h3FFFF, 1'b1, 1'b0);
`else
    conv("c262144", 32'h00262144, 18'h00000, 1'b1, 1'b0);
    conv("c9s", 32'h99999999, 18'h1E0FF, 1'b1, 1'b0);
`endif
    conv("cerr", 32'h0000A123, 18'h0, 1'b0, 1'b1);
    conv("czero", 32'h00000000, 18'h0, 1'b0, 1'b0);
    conv("c80000", 32'h00080000, 18'h13880, 1'b0, 1'b0);

    // Back-pressure: result must hold and a new request must be ignored.
    out_ready = 1'b0;
    start(32'h00000999);
    wait_out(lat);
    chk("bp_lat", lat, LAT);
    chk("bp_f", {14'd0, f}, 32'h3E7);
    f_hold   = f;
    bcd_in   = 32'h00000001;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_vld_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_f_hold", {14'd0, f}, {14'd0, f_hold});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_vld", {31'd0, out_valid}, 32'd0);
    chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    conv("bp_next", 32'h00000042, 18'h0002A, 1'b0, 1'b0);

    // Reset in the middle of a conversion aborts it.
    start(32'h00012345);
    repeat (11) tick();
    chk("mid_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_f", {14'd0, f}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    conv("after_abort", 32'h00000007, 18'h7, 1'b0, 1'b0);

    // Reset together with in_valid: no load happens.
    rst      = 1'b1;
    in_valid = 1'b1;
    bcd_in   = 32'h00000005;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rst_vs_valid_idle", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
